// File: rtl/dbi_tx_pkg.sv
// Shared types and constants for the DBI TX scheduler.
// Optional feature macro: DBI_TX_SCHED_AUTO_RAMWR_EN.
package dbi_tx_pkg;

    localparam int DEF_D_W = 8;
    localparam int DEF_FRAME_CNT_W = 20;
    localparam logic [7:0] DEF_RAMWR_CMD = 8'h2C;

    localparam logic DCX_CMD  = 1'b0;
    localparam logic DCX_DATA = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CMD   = 2'd1,
        RAMWR = 2'd2,
        PIXEL = 2'd3
    } state_t;

endpackage

// File: rtl/dbi_tx_out_reg.sv
// One-entry registered pipe stage carrying {dcx, data} to the DBI PHY.
// Full throughput: a new byte may load in the same cycle the old one drains.
module dbi_tx_out_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] in_data,
    input  logic         in_dcx,
    input  logic         in_vld,
    output logic         in_rdy,
    output logic [W-1:0] out_data,
    output logic         out_dcx,
    output logic         out_vld,
    input  logic         out_rdy
);

    assign in_rdy = ~out_vld | out_rdy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data <= '0;
            out_dcx  <= 1'b0;
            out_vld  <= 1'b0;
        end else if (in_vld && in_rdy) begin
            out_data <= in_data;
            out_dcx  <= in_dcx;
            out_vld  <= 1'b1;
        end else if (out_rdy) begin
            out_vld  <= 1'b0;
        end
    end

endmodule

// File: rtl/dbi_tx_scheduler.sv
// Arbitrates command and pixel byte streams onto the single DBI data lane.
// DBI_TX_SCHED_AUTO_RAMWR_EN prefixes every frame with the RAMWR opcode.
module dbi_tx_scheduler
    import dbi_tx_pkg::*;
#(
    parameter int DBI_IF_D_W  = DEF_D_W,
    parameter int FRAME_CNT_W = DEF_FRAME_CNT_W
`ifdef DBI_TX_SCHED_AUTO_RAMWR_EN
    ,
    parameter logic [DBI_IF_D_W-1:0] RAMWR_CMD = DEF_RAMWR_CMD
`endif
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [DBI_IF_D_W-1:0]  cmd_data_i,
    input  logic                   cmd_last_i,
    input  logic                   cmd_vld_i,
    output logic                   cmd_rdy_o,
    input  logic [DBI_IF_D_W-1:0]  pix_data_i,
    input  logic                   pix_vld_i,
    output logic                   pix_rdy_o,
    input  logic [FRAME_CNT_W-1:0] frame_bytes_i,
    output logic [DBI_IF_D_W-1:0]  dtp_d_data_o,
    output logic                   dtp_d_dcx_o,
    output logic                   dtp_d_vld_o,
    input  logic                   dtp_d_rdy_i,
    output logic                   busy_o,
    output logic                   frame_done_o
);

    state_t                 state, state_n;
    logic [FRAME_CNT_W-1:0] cnt, cnt_n;
    logic                   first, first_n;
    logic                   done_n;
    logic                   slot_free;
    logic                   ld_vld;
    logic [DBI_IF_D_W-1:0]  ld_data;
    logic                   ld_dcx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            cnt          <= '0;
            first        <= 1'b0;
            frame_done_o <= 1'b0;
        end else begin
            state        <= state_n;
            cnt          <= cnt_n;
            first        <= first_n;
            frame_done_o <= done_n;
        end
    end

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        first_n   = first;
        done_n    = 1'b0;
        cmd_rdy_o = 1'b0;
        pix_rdy_o = 1'b0;
        ld_vld    = 1'b0;
        ld_data   = '0;
        ld_dcx    = DCX_CMD;
        unique case (state)
            IDLE: begin
                // Commands win; a zero-length frame keeps pixels blocked.
                unique case (1'b1)
                    cmd_vld_i: begin
                        state_n = CMD;
                        first_n = 1'b1;
                    end
                    (pix_vld_i && !cmd_vld_i && (|frame_bytes_i)): begin
                        cnt_n = frame_bytes_i;
`ifdef DBI_TX_SCHED_AUTO_RAMWR_EN
                        state_n = RAMWR;
`else
                        state_n = PIXEL;
`endif
                    end
                    default: ;
                endcase
            end
            CMD: begin
                cmd_rdy_o = slot_free;
                if (cmd_vld_i && slot_free) begin
                    ld_vld  = 1'b1;
                    ld_data = cmd_data_i;
                    ld_dcx  = first ? DCX_CMD : DCX_DATA;
                    first_n = 1'b0;
                    if (cmd_last_i) state_n = IDLE;
                end
            end
`ifdef DBI_TX_SCHED_AUTO_RAMWR_EN
            RAMWR: begin
                if (slot_free) begin
                    ld_vld  = 1'b1;
                    ld_data = RAMWR_CMD;
                    ld_dcx  = DCX_CMD;
                    state_n = PIXEL;
                end
            end
`endif
            PIXEL: begin
                pix_rdy_o = slot_free;
                if (pix_vld_i && slot_free) begin
                    ld_vld  = 1'b1;
                    ld_data = pix_data_i;
                    ld_dcx  = DCX_DATA;
                    cnt_n   = cnt - 1'b1;
                    if (cnt == FRAME_CNT_W'(1)) begin
                        state_n = IDLE;
                        done_n  = 1'b1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    dbi_tx_out_reg #(
        .W (DBI_IF_D_W)
    ) u_out_reg (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_data  (ld_data),
        .in_dcx   (ld_dcx),
        .in_vld   (ld_vld),
        .in_rdy   (slot_free),
        .out_data (dtp_d_data_o),
        .out_dcx  (dtp_d_dcx_o),
        .out_vld  (dtp_d_vld_o),
        .out_rdy  (dtp_d_rdy_i)
    );

    assign busy_o = (state != IDLE) | dtp_d_vld_o;

endmodule

// File: tb/tb_dbi_tx_scheduler.sv
// Self-checking bench for dbi_tx_scheduler: cycle table plus frame sequences.
// Expected streams include the RAMWR prefix when DBI_TX_SCHED_AUTO_RAMWR_EN is set.
module tb_dbi_tx_scheduler;

    localparam logic H = 1'b1;
    localparam logic L = 1'b0;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  cmd_data;
    logic        cmd_last;
    logic        cmd_vld;
    logic        cmd_rdy;
    logic [7:0]  pix_data;
    logic        pix_vld;
    logic        pix_rdy;
    logic [19:0] frame_bytes;
    logic [7:0]  d_data;
    logic        d_dcx;
    logic        d_vld;
    logic        d_rdy;
    logic        busy;
    logic        frame_done;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int dones = 0;
    int done_cyc = 0;
    int last_out_cyc = 0;
    int overlap = 0;
    int pix_acc_cyc = 0;
    int cmd_acc_cyc = 0;
    logic [8:0] q[$];

    always #5 clk = ~clk;

    dbi_tx_scheduler dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .cmd_data_i    (cmd_data),
        .cmd_last_i    (cmd_last),
        .cmd_vld_i     (cmd_vld),
        .cmd_rdy_o     (cmd_rdy),
        .pix_data_i    (pix_data),
        .pix_vld_i     (pix_vld),
        .pix_rdy_o     (pix_rdy),
        .frame_bytes_i (frame_bytes),
        .dtp_d_data_o  (d_data),
        .dtp_d_dcx_o   (d_dcx),
        .dtp_d_vld_o   (d_vld),
        .dtp_d_rdy_i   (d_rdy),
        .busy_o        (busy),
        .frame_done_o  (frame_done)
    );

    // Output-side monitor, sampled mid-cycle well away from the posedge.
    always @(negedge clk) begin
        cyc = cyc + 1;
        #2;
        if (rst_n) begin
            if (d_vld && d_rdy) begin
                q.push_back({d_dcx, d_data});
                last_out_cyc = cyc;
            end
            if (frame_done) begin
                dones = dones + 1;
                done_cyc = cyc;
            end
            if (cmd_rdy && pix_rdy) overlap = overlap + 1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_stream(input string name, input logic [8:0] ex[$]);
        chk({name, "_len"}, q.size(), ex.size());
        for (int i = 0; i < ex.size() && i < q.size(); i++)
            chk($sformatf("%s_b%0d", name, i), {23'd0, q[i]}, {23'd0, ex[i]});
    endtask

    task automatic pix_byte(input logic [7:0] d);
        int t;
        t = 0;
        pix_vld = 1'b1;
        pix_data = d;
        #1;
        while (!pix_rdy && t < 100) begin
            @(negedge clk);
            #1;
            t++;
        end
        if (!pix_rdy) begin
            n_cmp++;
            n_err++;
            $display("FAIL pix_timeout: byte %0h not accepted", d);
        end
        pix_acc_cyc = cyc;
        @(negedge clk);
        pix_vld = 1'b0;
    endtask

    task automatic cmd_byte(input logic [7:0] d, input logic last);
        int t;
        t = 0;
        cmd_vld = 1'b1;
        cmd_data = d;
        cmd_last = last;
        #1;
        while (!cmd_rdy && t < 100) begin
            @(negedge clk);
            #1;
            t++;
        end
        if (!cmd_rdy) begin
            n_cmp++;
            n_err++;
            $display("FAIL cmd_timeout: byte %0h not accepted", d);
        end
        cmd_acc_cyc = cyc;
        @(negedge clk);
        cmd_vld = 1'b0;
        cmd_last = 1'b0;
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        #1;
        while (busy && t < 200) begin
            @(negedge clk);
            #1;
            t++;
        end
        if (busy) begin
            n_cmp++;
            n_err++;
            $display("FAIL idle_timeout: busy %0d expected 0", busy);
        end
        @(negedge clk);
    endtask

    task automatic frame_hdr(inout logic [8:0] ex[$]);
`ifdef DBI_TX_SCHED_AUTO_RAMWR_EN
        ex.push_back({1'b0, 8'h2C});
`else
        ex = ex;
`endif
    endtask

    typedef struct {
        logic        cv;
        logic [7:0]  cd;
        logic        cl;
        logic        pv;
        logic [19:0] fb;
        logic        dr;
        logic        crdy;
        logic        prdy;
        logic        vld;
        logic [7:0]  data;
        logic        dcx;
        logic        busy;
        logic        done;
        logic        chkd;
    } vec_t;

    vec_t tv[14];
    logic [8:0] ex[$];
    logic [7:0] hd;
    logic       hx;

    initial begin
        tv[0]  = '{L, 8'h00, L, L, 20'd0, H, L, L, L, 8'h00, L, L, L, H};
        tv[1]  = '{H, 8'h36, L, L, 20'd0, H, L, L, L, 8'h00, L, L, L, L};
        tv[2]  = '{H, 8'h36, L, L, 20'd0, H, H, L, L, 8'h00, L, H, L, L};
        tv[3]  = '{H, 8'h48, H, L, 20'd0, H, H, L, H, 8'h36, L, H, L, H};
        tv[4]  = '{L, 8'h00, L, L, 20'd0, H, L, L, H, 8'h48, H, H, L, H};
        tv[5]  = '{L, 8'h00, L, L, 20'd0, H, L, L, L, 8'h00, L, L, L, L};
        tv[6]  = '{L, 8'h00, L, H, 20'd0, H, L, L, L, 8'h00, L, L, L, L};
        tv[7]  = '{L, 8'h00, L, H, 20'd0, H, L, L, L, 8'h00, L, L, L, L};
        tv[8]  = '{H, 8'h11, H, L, 20'd0, L, L, L, L, 8'h00, L, L, L, L};
        tv[9]  = '{H, 8'h11, H, L, 20'd0, L, H, L, L, 8'h00, L, H, L, L};
        tv[10] = '{L, 8'h00, L, L, 20'd0, L, L, L, H, 8'h11, L, H, L, H};
        tv[11] = '{L, 8'h00, L, L, 20'd0, L, L, L, H, 8'h11, L, H, L, H};
        tv[12] = '{L, 8'h00, L, L, 20'd0, H, L, L, H, 8'h11, L, H, L, H};
        tv[13] = '{L, 8'h00, L, L, 20'd0, H, L, L, L, 8'h00, L, L, L, L};

        rst_n = 1'b0;
        cmd_data = '0;
        cmd_last = 1'b0;
        cmd_vld = 1'b0;
        pix_data = '0;
        pix_vld = 1'b0;
        frame_bytes = '0;
        d_rdy = 1'b1;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;

        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            cmd_vld = tv[i].cv;
            cmd_data = tv[i].cd;
            cmd_last = tv[i].cl;
            pix_vld = tv[i].pv;
            frame_bytes = tv[i].fb;
            d_rdy = tv[i].dr;
            #1;
            chk($sformatf("t%0d_cmd_rdy", i), cmd_rdy, tv[i].crdy);
            chk($sformatf("t%0d_pix_rdy", i), pix_rdy, tv[i].prdy);
            chk($sformatf("t%0d_vld", i), d_vld, tv[i].vld);
            chk($sformatf("t%0d_busy", i), busy, tv[i].busy);
            chk($sformatf("t%0d_done", i), frame_done, tv[i].done);
            if (tv[i].chkd) begin
                chk($sformatf("t%0d_data", i), d_data, tv[i].data);
                chk($sformatf("t%0d_dcx", i), d_dcx, tv[i].dcx);
            end
        end
        cmd_vld = 1'b0;
        cmd_last = 1'b0;
        pix_vld = 1'b0;
        d_rdy = 1'b1;
        @(negedge clk);

        // Single 4-byte frame.
        q.delete();
        dones = 0;
        frame_bytes = 20'd4;
        pix_byte(8'hA1);
        pix_byte(8'hA2);
        pix_byte(8'hA3);
        pix_byte(8'hA4);
        wait_idle();
        ex.delete();
        frame_hdr(ex);
        ex.push_back(9'h1A1);
        ex.push_back(9'h1A2);
        ex.push_back(9'h1A3);
        ex.push_back(9'h1A4);
        chk_stream("frame4", ex);
        chk("frame4_dones", dones, 1);
        chk("frame4_done_cyc", done_cyc, last_out_cyc);

        // Command and pixels raised together: command first.
        q.delete();
        dones = 0;
        frame_bytes = 20'd2;
        fork
            begin
                cmd_byte(8'h2A, 1'b0);
                cmd_byte(8'h00, 1'b0);
                cmd_byte(8'h01, 1'b1);
            end
            begin
                pix_byte(8'hB1);
                pix_byte(8'hB2);
            end
        join
        wait_idle();
        ex.delete();
        ex.push_back(9'h02A);
        ex.push_back(9'h100);
        ex.push_back(9'h101);
        frame_hdr(ex);
        ex.push_back(9'h1B1);
        ex.push_back(9'h1B2);
        chk_stream("prio", ex);
        chk("prio_dones", dones, 1);

        // Command arrives mid-frame and must wait for the whole frame.
        q.delete();
        dones = 0;
        frame_bytes = 20'd8;
        fork
            begin
                for (int i = 0; i < 8; i++) pix_byte(8'hC0 + 8'(i));
            end
            begin
                repeat (3) @(negedge clk);
                cmd_byte(8'h29, 1'b1);
            end
        join
        wait_idle();
        ex.delete();
        frame_hdr(ex);
        for (int i = 0; i < 8; i++) ex.push_back({1'b1, 8'hC0 + 8'(i)});
        ex.push_back(9'h029);
        chk_stream("midcmd", ex);
        chk("midcmd_gap", cmd_acc_cyc - pix_acc_cyc, 2);
        chk("midcmd_dones", dones, 1);

        // PHY stalls for 5 cycles mid-frame.
        q.delete();
        dones = 0;
        frame_bytes = 20'd4;
        fork
            begin
                pix_byte(8'hD1);
                pix_byte(8'hD2);
                pix_byte(8'hD3);
                pix_byte(8'hD4);
            end
            begin
                int t;
                t = 0;
                @(negedge clk);
                #1;
                while (!(d_vld && d_dcx) && t < 50) begin
                    @(negedge clk);
                    #1;
                    t++;
                end
                @(negedge clk);
                d_rdy = 1'b0;
                #1;
                hd = d_data;
                hx = d_dcx;
                chk("bp_vld0", d_vld, 1);
                for (int i = 1; i <= 5; i++) begin
                    @(negedge clk);
                    if (i == 5) d_rdy = 1'b1;
                    #1;
                    chk($sformatf("bp_data%0d", i), d_data, hd);
                    chk($sformatf("bp_dcx%0d", i), d_dcx, hx);
                    chk($sformatf("bp_vld%0d", i), d_vld, 1);
                    if (i < 5) chk($sformatf("bp_prdy%0d", i), pix_rdy, 0);
                end
            end
        join
        wait_idle();
        ex.delete();
        frame_hdr(ex);
        ex.push_back(9'h1D1);
        ex.push_back(9'h1D2);
        ex.push_back(9'h1D3);
        ex.push_back(9'h1D4);
        chk_stream("bp", ex);
        chk("bp_dones", dones, 1);

        // Reset after 2 of 6 pixels, then a fresh 3-byte frame.
        frame_bytes = 20'd6;
        pix_byte(8'hE1);
        pix_byte(8'hE2);
        pix_vld = 1'b1;
        pix_data = 8'hE3;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_cmd_rdy", cmd_rdy, 0);
        chk("rst_pix_rdy", pix_rdy, 0);
        chk("rst_data", d_data, 0);
        chk("rst_dcx", d_dcx, 0);
        chk("rst_vld", d_vld, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", frame_done, 0);
        pix_vld = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b1;
        q.delete();
        dones = 0;
        @(negedge clk);
        frame_bytes = 20'd3;
        pix_byte(8'hF1);
        pix_byte(8'hF2);
        pix_byte(8'hF3);
        wait_idle();
        ex.delete();
        frame_hdr(ex);
        ex.push_back(9'h1F1);
        ex.push_back(9'h1F2);
        ex.push_back(9'h1F3);
        chk_stream("postrst", ex);
        chk("postrst_dones", dones, 1);
        chk("rdy_overlap", overlap, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
